// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the 8N1 UART blocks: receiver state
//           encoding, frame width and the default board clock / line rate
//           used by both uart_rx_8n1 and the uart_tx_8n1 baud logic.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Data bits per frame (8N1).
  localparam int DATA_BITS = 8;

  // Board defaults: 12 MHz system clock, 9600 bit/s line.
  localparam int DEFAULT_CLK_FREQ = 12_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  // Receiver framing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, integer floor.
  function automatic int calc_tick_div(input int clk_freq, input int baud,
                                       input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Purpose : Restartable clock divider. Emits a one-cycle tick every TICK_DIV
//           clocks. A restart zeroes the count so the next tick lands exactly
//           TICK_DIV clocks later, letting a receiver lock its sampling phase
//           to a start edge. Also usable as the uart_tx_8n1 bit-rate source.
// Ports   : clk     - system clock
//           rst_n   - synchronous active-low reset
//           restart - clear the divider (takes priority over counting)
//           tick    - one-cycle pulse on the last count of each period
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int TICK_DIV = 78
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // The tick coincides with the wrap back to zero.
  assign tick = (cnt == LAST);

endmodule : uart_baud_tick

`default_nettype wire

// File: rtl/uart_rx_8n1.sv
// ============================================================================
// Module  : uart_rx_8n1
// Purpose : 8N1 UART receiver. Synchronises the asynchronous rx pin,
//           oversamples it OVERSAMPLE times per bit, deframes start / 8 data
//           (LSB first) / stop, and presents each byte on a valid/ready
//           holding register.
// Ports   : clk         - system clock
//           rst_n       - synchronous active-low reset
//           rx          - asynchronous serial input, idle high
//           rx_data     - received byte, stable while rx_valid is high
//           rx_valid    - byte available, held until rx_valid && rx_ready
//           rx_ready    - consumer accepts the byte
//           frame_err   - one-cycle pulse: stop bit sampled low
//           overrun_err - one-cycle pulse: byte completed while still full
//           busy        - receiver not idle
// Config  : `define UART_RX_MAJORITY_EN to decide every bit (start bit
//           included) by a 2-of-3 vote over the ticks at mid-1, mid, mid+1.
//           Without it a single sample at mid is used.
// Params  : OVERSAMPLE must be even and >= 8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OSW      = $clog2(OVERSAMPLE);
  localparam int BIW      = $clog2(DATA_BITS);

  // Oversample counts are taken before the increment, so the tick seen with
  // os_cnt == N is the (N+1)th tick since the counter was cleared. The
  // start-bit mid point is therefore os_cnt == OVERSAMPLE/2-1. Once the start
  // bit is confirmed os_cnt is cleared, so each later bit is decided when the
  // counter wraps, a whole bit period after the previous decision.
  //
  // With the vote enabled every decision slips one tick later so that the
  // mid+1 sample is available; the spacing between decisions is unchanged.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [OSW-1:0] START_PT = OSW'(OVERSAMPLE / 2);
`else
  localparam logic [OSW-1:0] START_PT = OSW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [OSW-1:0] BIT_PT   = OSW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Input synchroniser (idle-high reset so no false start after reset)
  // --------------------------------------------------------------------------
  logic sync_1;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx;
      rx_s   <= sync_1;
    end
  end

  // --------------------------------------------------------------------------
  // Oversample tick, phase-locked to the start edge
  // --------------------------------------------------------------------------
  logic tick_restart;
  logic os_tick;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tick_restart),
    .tick    (os_tick)
  );

  // --------------------------------------------------------------------------
  // Bit value at the decision tick
  // --------------------------------------------------------------------------
  logic sample;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] / hist[1] hold the line one and two ticks back; together with
  // the current value they form the three-sample vote.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (os_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  rx_state_e state;
  rx_state_e state_nxt;

  logic [OSW-1:0]       os_cnt;
  logic [BIW-1:0]       bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic os_clr;
  logic bit_clr;
  logic shift_en;
  logic byte_done;
  logic frame_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_restart = 1'b0;
    os_clr       = 1'b0;
    bit_clr      = 1'b0;
    shift_en     = 1'b0;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt    = START;
          tick_restart = 1'b1;
          os_clr       = 1'b1;
          bit_clr      = 1'b1;
        end
      end

      START: begin
        if (os_tick && (os_cnt == START_PT)) begin
          if (sample) begin
            // Line back high by mid-bit: noise, not a start bit.
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            os_clr    = 1'b1;
            bit_clr   = 1'b1;
          end
        end
      end

      DATA: begin
        if (os_tick && (os_cnt == BIT_PT)) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        if (os_tick && (os_cnt == BIT_PT)) begin
          if (sample) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold off until the line returns high so a stuck-low line is not
        // decoded as a stream of zero bytes.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      os_cnt <= '0;
    end else if (os_clr) begin
      os_cnt <= '0;
    end else if (os_tick) begin
      os_cnt <= (os_cnt == BIT_PT) ? '0 : os_cnt + OSW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (bit_clr) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + BIW'(1);
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {sample, shreg[DATA_BITS-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Holding register and status pulses
  // --------------------------------------------------------------------------
  logic accept;
  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_bad;
      // A handshake in the completion cycle frees the register, so the new
      // byte is taken and no overrun is reported.
      overrun_err <= byte_done && rx_valid && !rx_ready;
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule : uart_rx_8n1

`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
// ============================================================================
// Module  : tb_uart_rx_8n1
// Purpose : Self-checking bench for uart_rx_8n1. The receiver runs from a
//           2 MHz clock at 9600 bit/s (13 clocks per tick, same 0.16% tick
//           rounding as the 12 MHz board), while the line is driven at the
//           exact rate with bit edges at floor(k*CLK_FREQ/BAUD).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_8n1;

  localparam int CLK_FREQ = 2_000_000;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int BITC     = CLK_FREQ / BAUD;   // ~208 clocks per bit

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_8n1 #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Monitors (sampled on the falling edge)
  // --------------------------------------------------------------------------
  int cyc      = 0;
  int n_frame  = 0;
  int n_over   = 0;
  int n_busy   = 0;
  int rise_cyc = 0;
  logic valid_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)   n_frame = n_frame + 1;
      if (overrun_err) n_over  = n_over + 1;
      if (busy)        n_busy  = n_busy + 1;
    end
    if (rx_valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_valid;
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int edge_at(input int k);
    return int'((longint'(k) * CLK_FREQ) / BAUD);
  endfunction

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) hold(bits[k], edge_at(k + 1) - edge_at(k));
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!rx_valid && n < 3 * BITC * 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, " valid"}, int'(rx_valid), 1);
  endtask

  // Handshake one cycle after valid was seen; valid must drop right after.
  task automatic accept(input string name);
    @(negedge clk);
    chk({name, " valid held"}, int'(rx_valid), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({name, " valid cleared"}, int'(rx_valid), 0);
  endtask

  // --------------------------------------------------------------------------
  // Table of clean frames
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_data;
    int         exp_frame;
    int         exp_over;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #(5_000_000);
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bf;
    int bo;
    int bb;
    logic [7:0] exp_glitch;
    logic [9:0] a5_bits;

    vecs[0] = '{8'h41, 8'h41, 0, 0};
    vecs[1] = '{8'hFF, 8'hFF, 0, 0};
    vecs[2] = '{8'h00, 8'h00, 0, 0};
    vecs[3] = '{8'h80, 8'h80, 0, 0};
    vecs[4] = '{8'h01, 8'h01, 0, 0};

    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset rx_valid", int'(rx_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset overrun_err", int'(overrun_err), 0);
    hold(1'b1, BITC);

    // Clean frames
    for (int i = 0; i < 5; i++) begin
      bf = n_frame;
      bo = n_over;
      send_frame(vecs[i].tx, 1'b1);
      wait_valid($sformatf("vec%0d", i));
      chk($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      // Stop-bit decision lands ~9.5 bit times after the start edge.
      chk_range($sformatf("vec%0d latency", i), rise_cyc - start_cyc,
                (BITC * 93) / 10, (BITC * 97) / 10);
      chk($sformatf("vec%0d frame_err", i), n_frame - bf, vecs[i].exp_frame);
      chk($sformatf("vec%0d overrun_err", i), n_over - bo, vecs[i].exp_over);
      accept($sformatf("vec%0d", i));
      hold(1'b1, BITC);
    end

    // False start: three ticks low
    bf = n_frame;
    bo = n_over;
    bb = n_busy;
    hold(1'b0, 3 * (CLK_FREQ / (BAUD * OS)));
    hold(1'b1, 2 * BITC);
    chk("false start busy seen", int'((n_busy - bb) > 0), 1);
    chk("false start busy idle", int'(busy), 0);
    chk("false start rx_valid", int'(rx_valid), 0);
    chk("false start frame_err", n_frame - bf, 0);
    chk("false start overrun_err", n_over - bo, 0);

    // Framing error, line held low two more bit times
    bf = n_frame;
    bo = n_over;
    send_frame(8'h55, 1'b0);
    hold(1'b0, 2 * BITC);
    chk("break busy", int'(busy), 1);
    chk("break frame_err count", n_frame - bf, 1);
    chk("break rx_valid", int'(rx_valid), 0);
    hold(1'b1, 20);
    chk("break released busy", int'(busy), 0);
    send_frame(8'h0A, 1'b1);
    wait_valid("after break");
    chk("after break rx_data", int'(rx_data), 8'h0A);
    chk("after break frame_err count", n_frame - bf, 1);
    chk("after break overrun_err", n_over - bo, 0);
    accept("after break");
    hold(1'b1, BITC);

    // Overrun: two frames back-to-back, nobody accepting
    bf = n_frame;
    bo = n_over;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 50);
    chk("overrun count", n_over - bo, 1);
    chk("overrun rx_data kept", int'(rx_data), 8'h11);
    chk("overrun rx_valid", int'(rx_valid), 1);
    chk("overrun frame_err", n_frame - bf, 0);
    accept("overrun");
    hold(1'b1, BITC);

    // Reset during data bit 4 of 0xA5; the transmitter then gives up
    bf = n_frame;
    bo = n_over;
    a5_bits = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 5; k++) hold(a5_bits[k], edge_at(k + 1) - edge_at(k));
    hold(1'b0, BITC / 2);
    chk("abort busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx    = 1'b1;
    chk("abort rx_data cleared", int'(rx_data), 0);
    chk("abort busy after reset", int'(busy), 0);
    hold(1'b1, 3 * BITC);
    chk("abort rx_valid", int'(rx_valid), 0);
    chk("abort frame_err", n_frame - bf, 0);
    chk("abort overrun_err", n_over - bo, 0);
    send_frame(8'h3C, 1'b1);
    wait_valid("after abort");
    chk("after abort rx_data", int'(rx_data), 8'h3C);
    accept("after abort");
    hold(1'b1, BITC);

    // One-tick glitch high across the mid-sample of data bit 2 of 0x00
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h00;
`else
    exp_glitch = 8'h04;
`endif
    bf = n_frame;
    start_cyc = cyc;
    hold(1'b0, edge_at(3) + BITC / 2 - 6);
    hold(1'b1, CLK_FREQ / (BAUD * OS));
    hold(1'b0, edge_at(9) - (edge_at(3) + BITC / 2 - 6) - CLK_FREQ / (BAUD * OS));
    hold(1'b1, edge_at(10) - edge_at(9));
    wait_valid("glitch");
    chk("glitch rx_data", int'(rx_data), int'(exp_glitch));
    chk("glitch frame_err", n_frame - bf, 0);
    accept("glitch");
    hold(1'b1, BITC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_8n1

`default_nettype wire

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- 8N1 UART receiver: the receive-side counterpart to the existing uart_tx_8n1 transmitter.
- Consumes the asynchronous board uartrx pin, synchronises and oversamples it from the 12 MHz system clock, and deframes start, data and stop bits.
- Presents each received byte on a valid/ready holding register for the downstream message/command logic, e.g. the echo and LED control logic in top.

Parameters:
- CLK_FREQ, 12000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: oversample ticks per bit. Must be even and at least 8.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE): clocks per oversample tick, integer floor (78 at the defaults). Localparam, not overridable.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset.
- rx, input, 1: asynchronous serial line. Idle state is high.
- rx_data, output, 8: received byte, held stable while rx_valid=1.
- rx_valid, output, 1: byte available. Stays high until accepted.
- rx_ready, input, 1: consumer accepts. The transfer happens when rx_valid&&rx_ready at a clk edge.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
- overrun_err, output, 1: one-cycle pulse when a byte completes while rx_valid=1.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All flops update on posedge clk only.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
  - Synchroniser flops = 1.
  - Tick counter, oversample counter and bit index = 0.
  - State = IDLE.
  - Reset asserted mid-frame aborts the frame with no output pulse.
- Synchroniser: 2-flop, giving rx_s. Two-cycle input latency.
- Tick generator:
  - Counter runs 0..TICK_DIV-1, and os_tick pulses when it wraps.
  - The counter is cleared on the IDLE->START transition, so sampling phase is aligned to the start edge.
- Oversample counter os_cnt runs 0..OVERSAMPLE-1 and advances on os_tick.
- Mid-bit sample point is os_cnt==OVERSAMPLE/2-1 (7 at the defaults).
- FSM:
  - IDLE: when rx_s==0, clear the counters and go to START.
  - START: at the mid-point, if the sample is 1 it is a false start, so return to IDLE with no pulse. Otherwise clear os_cnt, set bit index 0, go to DATA. Later samples are therefore full bit periods apart (OVERSAMPLE ticks).
  - DATA: every OVERSAMPLE ticks, shift the sample into the shift register LSB-first. After bit index 7, go to STOP.
  - STOP, after OVERSAMPLE ticks, sample the line:
    - Sample 1 and rx_valid=0: load rx_data, set rx_valid, go to IDLE.
    - Sample 1 and rx_valid=1: pulse overrun_err. The new byte is dropped and the old rx_data is retained unchanged. Go to IDLE.
    - Sample 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 bytes.
- Latency: rx_valid rises on the clk edge after the stop-bit sample, about 9.5 bit times after the start edge.
- rx_valid clears on the cycle after a handshake.
- Simultaneous handshake and new-byte completion in the same cycle: the handshake takes priority. The new byte loads, rx_valid stays 1, and there is no overrun.
- Baud-rate error: the tick rounding error at the defaults (0.16%) must be tolerated across a full frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the majority of 3 samples taken at os_cnt = mid-1, mid and mid+1. The start-bit check also uses the majority. A single-tick glitch is rejected.
- Undefined: a single sample at mid. The extra sample flops are not built.

Decomposition:
- Package uart_pkg:
  - state enum IDLE/START/DATA/STOP/BREAK;
  - DATA_BITS=8;
  - default CLK_FREQ/BAUD constants, also used by the uart_tx_8n1 baud logic.
- One natural sub-module: uart_baud_tick, the restartable TICK_DIV divider. It is reusable to drive uart_tx_8n1 from the system clock.

Test Plan:
- Send 0x41 'A' at 9600 baud, then assert rx_ready one cycle after rx_valid -> rx_data=0x41, rx_valid high until the handshake, frame_err=0, overrun_err=0.
- Pull rx low for 3 oversample ticks (about 19.5 us), then high -> busy pulses, then returns to IDLE; rx_valid stays 0; no error pulses.
- Send 0x55 with the stop bit forced 0, line low for a further 2 bit times -> frame_err pulses exactly once; rx_valid stays 0; busy holds until the line goes high. A following 0x0A byte is received correctly.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> overrun_err pulses once; rx_data stays 0x11. After the handshake, rx_valid=0.
- Assert rst_n=0 for one cycle during data bit 4 of 0xA5, then send 0x3C -> no pulse for the aborted frame; 0x3C is received.
- With UART_RX_MAJORITY_EN defined, flip rx for one tick at the mid-sample of bit 2 of 0x00 -> rx_data=0x00. Macro undefined -> rx_data=0x04.
